// File: rtl/fp32_divider.sv
// FP32 divider: radix-2 restoring mantissa division, one quotient bit per clock.
// Valid/ready on both sides, a single operation in flight, result held until taken.
module fp32_divider #(
  parameter int ROUND_MODE = 0,
  parameter int FTZ        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_z,
  output logic [3:0]  out_flags
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [25:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [22:0]       frac_q, frac_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       z_q, z_d;
  logic [3:0]        flags_q, flags_d;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        ftz_on;

  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign fa = a_q[22:0];
  assign fb = b_q[22:0];
  assign ftz_on = (FTZ != 0);

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00) && (ftz_on || fa == 23'd0);
  assign b_zero = (eb == 8'h00) && (ftz_on || fb == 23'd0);

  logic              ge;
  logic [24:0]       diff;
  logic [24:0]       rem_sel;
  logic              inc;
  logic              carry;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    flags_d  = flags_q;

    ge      = rem_q >= {1'b0, div_q};
    diff    = rem_q - {1'b0, div_q};
    rem_sel = ge ? diff : rem_q;

    inc = (ROUND_MODE == 0) && guard_q && (sticky_q || frac_q[0]);
    {carry, frac_r} = {1'b0, frac_q} + {23'd0, inc};
    exp_r = exp_q + (carry ? 10'sd1 : 10'sd0);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = input_a;
          b_d     = input_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = a_q[31] ^ b_q[31];
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          z_d     = 32'h7FC0_0000;
          flags_d = 4'b1000;
          state_d = S_DONE;
        end else if (a_inf) begin
          z_d     = {sign_d, 8'hFF, 23'd0};
          flags_d = 4'b0000;
          state_d = S_DONE;
        end else if (b_zero) begin
          z_d     = {sign_d, 8'hFF, 23'd0};
          flags_d = 4'b0100;
          state_d = S_DONE;
        end else if (a_zero || b_inf) begin
          z_d     = {sign_d, 31'd0};
          flags_d = 4'b0000;
          state_d = S_DONE;
        end else begin
          rem_d   = {2'b01, fa};
          div_d   = {1'b1, fb};
          quo_d   = 26'd0;
          cnt_d   = 5'd0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = rem_sel << 1;
        quo_d = {quo_q[24:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = S_NORM;
      end
      S_NORM: begin
        // q[24] is the hidden bit whenever the integer bit came out zero
        if (quo_q[25]) begin
          frac_d   = quo_q[24:2];
          guard_d  = quo_q[1];
          sticky_d = quo_q[0] || (rem_q != 25'd0);
        end else begin
          exp_d    = exp_q - 10'sd1;
          frac_d   = quo_q[23:1];
          guard_d  = quo_q[0];
          sticky_d = (rem_q != 25'd0);
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (exp_r >= 10'sd255) begin
          if (ROUND_MODE == 0) z_d = {sign_q, 8'hFF, 23'd0};
          else z_d = {sign_q, 8'hFE, 23'h7F_FFFF};
          flags_d = 4'b0010;
        end else if (exp_r <= 10'sd0) begin
          z_d     = {sign_q, 31'd0};
          flags_d = 4'b0001;
        end else begin
          z_d     = {sign_q, exp_r[7:0], frac_r};
          flags_d = 4'b0000;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign output_z  = z_q;
  assign out_flags = flags_q;

endmodule
